// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage with dmem handshake, alignment faults and access timeout
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        stall,
  output logic [31:0] bp_mem,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q, ld_w, ld_val;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          rw_q, we_q;
  logic          mem_op, fault, accept, st_done, ld_done, tmo;
  assign mem_op = in_valid & (mem_read | mem_write);
  assign fault = mem_op & ((mem_read & mem_write) | (funct3 == 3'b011) | (funct3[2:1] == 2'b11) |
                 ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00)) |
                 ((funct3[1:0] == 2'b01) & alu_result[0]));
  assign accept = (state == IDLE) & mem_op & ~fault;
  assign st_done = (state == REQ) & dmem_req_ready & we_q;
  assign ld_done = (state == RESP) & dmem_rsp_valid;
  assign tmo = (state != IDLE) & (cnt == CW'(TIMEOUT - 1)) & ~st_done & ~ld_done;
  assign stall = rst_n & (accept | ((state != IDLE) & ~st_done & ~ld_done & ~tmo));
  assign bp_mem = alu_result;
  assign dmem_req_valid = rst_n & (state == REQ);
  assign dmem_req_we = we_q;
  assign dmem_req_addr = {addr_q[31:2], 2'b00};
  assign dmem_req_be = !we_q ? 4'hf :
                       (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                       (f3_q[1:0] == 2'b01) ? 4'b0011 << addr_q[1:0] : 4'hf;
  assign dmem_req_wdata = (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                          (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
  // alignment is guaranteed, so a byte-granular shift also selects the right half
  assign ld_w = dmem_rsp_rdata >> {addr_q[1:0], 3'b000};
  assign ld_val = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & ld_w[7]}}, ld_w[7:0]} :
                  (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & ld_w[15]}}, ld_w[15:0]} : dmem_rsp_rdata;
  always_ff @(posedge clk)
    if (accept) begin
      addr_q  <= alu_result;
      wdata_q <= write_data;
      f3_q    <= funct3;
      rd_q    <= rd;
      rw_q    <= reg_write;
      we_q    <= mem_write;
    end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
      cnt          <= (state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        if (accept)
          state <= REQ;
        else if (in_valid) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= reg_write & ~mem_op;
          wb_rd        <= rd;
          wb_data      <= alu_result;
          mem_err      <= fault;
        end
      end else if (tmo | st_done | ld_done) begin
        state        <= IDLE;
        wb_valid     <= 1'b1;
        wb_reg_write <= ld_done & rw_q;
        wb_rd        <= rd_q;
        wb_data      <= ld_val;
        mem_err      <= tmo;
      end else if (state == REQ && dmem_req_ready)
        state <= RESP;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage writeback, dmem request fields, faults and timeout
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic        dmem_req_valid, dmem_req_we;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        stall, wb_valid, wb_reg_write, mem_err;
  logic [31:0] bp_mem, wb_data;
  logic [4:0]  wb_rd;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .rd(rd), .funct3(funct3),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .stall(stall), .bp_mem(bp_mem), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );
  typedef struct packed {logic rw; logic [4:0] rd; logic [31:0] data; logic err; logic cd;} wb_t;
  wb_t exp_q[$];
  wb_t e;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic wb_t mk(input logic rw, input logic [4:0] r, input logic [31:0] d, input logic err, input logic cd);
    wb_t w;
    w.rw = rw;
    w.rd = r;
    w.data = d;
    w.err = err;
    w.cd = cd;
    return w;
  endfunction
  task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic [4:0] r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    in_valid = v;
    mem_read = mr;
    mem_write = mw;
    reg_write = rw;
    rd = r;
    funct3 = f;
    alu_result = a;
    write_data = wd;
  endtask
  // every retirement is matched in order against the queue
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (exp_q.size() == 0) chk("wb_extra", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("wb_reg_write", wb_reg_write, e.rw);
        chk("wb_mem_err", mem_err, e.err);
        if (e.cd) begin
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end else if (rst_n && mem_err) chk("err_bubble", mem_err, 0);
  end
  task automatic run_nonmem(input logic rw, input logic [4:0] r, input logic [31:0] a);
    drive(1, 0, 0, rw, r, 3'b000, a, 32'h5555_0000);
    exp_q.push_back(mk(rw, r, a, 0, 1));
    @(negedge clk);
    chk("nm_stall", stall, 0);
    chk("nm_bp_mem", bp_mem, a);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("nm_wb_valid", wb_valid, 1);
    @(posedge clk); #1;
    chk("bubble_wb_valid", wb_valid, 0);
  endtask
  task automatic run_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rdata,
                          input logic [31:0] exp, input int gap);
    drive(1, 1, 0, 1, 5'd7, f, a, 32'h0);
    exp_q.push_back(mk(1, 5'd7, exp, 0, 1));
    @(negedge clk);
    chk("ld_stall_accept", stall, 1);
    chk("ld_no_req_idle", dmem_req_valid, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 32'h0BAD_0000, 0);
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("ld_req_valid", dmem_req_valid, 1);
    chk("ld_req_we", dmem_req_we, 0);
    chk("ld_req_addr", dmem_req_addr, a & ~32'h3);
    chk("ld_req_be", dmem_req_be, 4'hf);
    chk("ld_stall_req", stall, 1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("ld_stall_resp", stall, 1);
      chk("ld_req_dropped", dmem_req_valid, 0);
      @(posedge clk); #1;
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = rdata;
    @(negedge clk);
    chk("ld_stall_rsp", stall, 0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    chk("ld_wb_data_direct", wb_data, exp);
  endtask
  task automatic run_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] wdat, input int hold);
    drive(1, 0, 1, 1, 5'd9, f, a, wd);
    exp_q.push_back(mk(0, 5'd9, 0, 0, 0));
    @(negedge clk);
    chk("st_stall_accept", stall, 1);
    @(posedge clk); #1;
    drive(1, 0, 0, 1, 5'd3, 3'b000, 32'hDEAD_0000, 0);
    for (int i = 0; i <= hold; i++) begin
      dmem_req_ready = (i == hold);
      @(negedge clk);
      chk("st_req_valid", dmem_req_valid, 1);
      chk("st_req_we", dmem_req_we, 1);
      chk("st_req_addr", dmem_req_addr, a & ~32'h3);
      chk("st_req_be", dmem_req_be, be);
      chk("st_req_wdata", dmem_req_wdata, wdat);
      chk("st_stall", stall, (i != hold));
      @(posedge clk); #1;
    end
    dmem_req_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_reg_write", wb_reg_write, 0);
  endtask
  task automatic run_fault(input logic mr, input logic mw, input logic [2:0] f, input logic [31:0] a);
    drive(1, mr, mw, 1, 5'd12, f, a, 32'h1);
    exp_q.push_back(mk(0, 5'd12, 0, 1, 0));
    @(negedge clk);
    chk("flt_stall", stall, 0);
    chk("flt_no_req", dmem_req_valid, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flt_mem_err", mem_err, 1);
    chk("flt_wb_reg_write", wb_reg_write, 0);
    @(negedge clk);
    chk("flt_no_req_after", dmem_req_valid, 0);
    @(posedge clk); #1;
    chk("flt_err_one_cycle", mem_err, 0);
  endtask
  task automatic run_timeout(input logic is_store);
    int n;
    drive(1, ~is_store, is_store, 1, 5'd13, 3'b010, 32'h300, 32'h77);
    exp_q.push_back(mk(0, 5'd13, 0, 1, 0));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_req_ready = ~is_store;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
    end
    chk("tmo_stall_cycles", n, 63);
    @(posedge clk); #1;
    chk("tmo_mem_err", mem_err, 1);
    chk("tmo_req_dropped", dmem_req_valid, 0);
    chk("tmo_wb_reg_write", wb_reg_write, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req_valid", dmem_req_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_nonmem(1, 5'd5, 32'h1234);
    run_nonmem(0, 5'd20, 32'hFFFF_0000);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("stray_rsp_stall", stall, 0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    chk("stray_rsp_wb", wb_valid, 0);
    run_load(3'b000, 32'h103, 32'h80FF_FF00, 32'hFFFF_FF80, 1);
    run_load(3'b100, 32'h102, 32'h1234_5678, 32'h0000_0034, 0);
    run_load(3'b000, 32'h101, 32'h1122_C344, 32'hFFFF_FFC3, 2);
    run_load(3'b001, 32'h102, 32'h8001_1234, 32'hFFFF_8001, 0);
    run_load(3'b101, 32'h100, 32'h1234_F00D, 32'h0000_F00D, 1);
    run_load(3'b001, 32'h100, 32'hFFFF_7ABC, 32'h0000_7ABC, 0);
    run_load(3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);
    run_load(3'b100, 32'h100, 32'h0000_00A5, 32'h0000_00A5, 0);
    run_store(3'b001, 32'h102, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
    run_store(3'b000, 32'h101, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 0);
    run_store(3'b000, 32'h103, 32'h1234_56C7, 4'b1000, 32'hC7C7_C7C7, 1);
    run_store(3'b010, 32'h200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 2);
    run_store(3'b001, 32'h100, 32'h0000_1357, 4'b0011, 32'h1357_1357, 0);
    run_fault(1, 0, 3'b010, 32'h101);
    run_fault(1, 0, 3'b001, 32'h103);
    run_fault(0, 1, 3'b010, 32'h102);
    run_fault(0, 1, 3'b001, 32'h105);
    run_fault(1, 1, 3'b010, 32'h100);
    run_fault(1, 0, 3'b011, 32'h100);
    run_fault(0, 1, 3'b110, 32'h100);
    run_fault(1, 0, 3'b111, 32'h100);
    run_timeout(0);
    run_timeout(1);
    drive(1, 1, 0, 1, 5'd14, 3'b010, 32'h400, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_req_valid", dmem_req_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid_wb_valid", wb_valid, 0);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("late_rsp_stall", stall, 0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_wb_valid", wb_valid, 0);
    run_nonmem(1, 5'd31, 32'h0000_0042);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
